// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//   Receives device-to-host PS/2 keyboard frames (start, 8 data bits LSB-first,
//   odd parity, stop) from the raw clock/data pins. It de-glitches both pins,
//   checks framing and parity, and queues good scan-code bytes in a
//   first-word-fall-through FIFO that the CPU reads.
//
// Parameters
//   FILTER_LEN      consecutive differing synced samples before a filtered level changes
//   TIMEOUT_CYCLES  clk cycles allowed between frame falling edges before abandoning a frame
//   FIFO_AW         FIFO address width (depth = 2**FIFO_AW)
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   ps2_clock    raw PS/2 clock pin (asynchronous)
//   ps2_data     raw PS/2 data pin (asynchronous)
//   rd_en        pop the head byte (ignored while rd_valid is low)
//   rd_data      head byte of the FIFO, 0 while empty
//   rd_valid     FIFO not empty
//   frame_error  sticky: bad start/parity/stop bit or inter-edge timeout
//   overflow     sticky: good byte dropped because the FIFO was full
//   clear_err    clears frame_error and overflow (a new set in the same cycle wins)
`timescale 1ns/1ps

module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_AW        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_error,
  output logic       overflow,
  input  logic       clear_err
);

  localparam int CW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchronizer and run-length glitch filter per pin.
  // The filtered level only follows the synced pin after FILTER_LEN
  // consecutive samples that disagree with it; any agreeing sample restarts
  // the count.
  // ---------------------------------------------------------------------------
  logic          clk_sync1, clk_sync2, clk_filt, clk_prev;
  logic          dat_sync1, dat_sync2, dat_filt;
  logic [CW-1:0] clk_cnt, dat_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync1 <= 1'b1;
      clk_sync2 <= 1'b1;
      clk_filt  <= 1'b1;
      clk_cnt   <= '0;
    end else begin
      clk_sync1 <= ps2_clock;
      clk_sync2 <= clk_sync1;
      if (clk_sync2 == clk_filt) begin
        clk_cnt <= '0;
      end else if (clk_cnt == CW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync2;
        clk_cnt  <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_sync1 <= 1'b1;
      dat_sync2 <= 1'b1;
      dat_filt  <= 1'b1;
      dat_cnt   <= '0;
    end else begin
      dat_sync1 <= ps2_data;
      dat_sync2 <= dat_sync1;
      if (dat_sync2 == dat_filt) begin
        dat_cnt <= '0;
      end else if (dat_cnt == CW'(FILTER_LEN - 1)) begin
        dat_filt <= dat_sync2;
        dat_cnt  <= '0;
      end else begin
        dat_cnt <= dat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev <= 1'b1;
    end else begin
      clk_prev <= clk_filt;
    end
  end

  // One-cycle pulse in the cycle the filtered clock first reads low.
  logic fall;
  assign fall = clk_prev & ~clk_filt;

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  state_t        state, state_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shift, shift_next;
  logic          parity, parity_next;
  logic [TW-1:0] timer, timer_next;
  logic          push;
  logic          err_set;
  logic          timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      parity  <= 1'b0;
      timer   <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
      parity  <= parity_next;
      timer   <= timer_next;
    end
  end

  // A falling edge in the same cycle the timer expires still counts as an
  // edge, so the timeout only fires when no edge arrives.
  assign timeout = (state != IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    parity_next  = parity;
    timer_next   = timer;
    push         = 1'b0;
    err_set      = 1'b0;

    if (state == IDLE || fall) begin
      timer_next = '0;
    end else begin
      timer_next = timer + 1'b1;
    end

    case (state)
      IDLE: begin
        if (fall) begin
          if (!dat_filt) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shift_next   = {dat_filt, shift[7:1]};
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parity_next = dat_filt;
          state_next  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_next = IDLE;
          if (dat_filt && ((^shift) ^ parity)) begin
            push = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (timeout) begin
      state_next = IDLE;
      timer_next = '0;
      err_set    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT FIFO. Pointers carry one extra wrap bit so full and empty are
  // distinguishable without a separate count.
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             full;
  logic             pop;
  logic             wr_accept;
  logic             drop;

  assign rd_valid  = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop       = rd_en & rd_valid;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign wr_accept = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign rd_data   = rd_valid ? mem[rd_ptr[FIFO_AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= shift;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (err_set) begin
        frame_error <= 1'b1;
      end else if (clear_err) begin
        frame_error <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Testbench for ps2_keyboard_rx: drives PS/2 frames on the pins, predicts the
// received bytes and sticky flags from the frame contents, and checks the
// FIFO output with an independent reader/monitor process.
`timescale 1ns/1ps

module tb_ps2_keyboard_rx;

  localparam int FL    = 4;
  localparam int TO    = 400;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int H     = 20;   // PS/2 half-period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clock;
  logic       ps2_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_error;
  logic       overflow;
  logic       clear_err;

  ps2_keyboard_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO),
    .FIFO_AW       (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clock  (ps2_clock),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .frame_error(frame_error),
    .overflow   (overflow),
    .clear_err  (clear_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] exp_q[$];
  bit         exp_err;
  bit         exp_ovf;
  bit         reading;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: whenever the DUT presents a byte and the reader is enabled, the
  // byte is popped and compared with the oldest predicted byte.
  initial begin
    rd_en = 1'b0;
    forever begin
      @(negedge clk);
      if (reading && rd_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_byte", {24'd0, rd_data}, 32'hFFFF_FFFF);
        end else begin
          check("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        end
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
    end
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;   // odd parity: data ones + parity bit is odd
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Drives the first n bits of a frame, device-style: data changes while the
  // clock is high, the host samples on the falling edge.
  task automatic drive_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (H / 2) @(negedge clk);
      if (glitch && i >= 2 && i <= 6) begin
        ps2_clock = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clock = 1'b1;
      end
      repeat (H / 2) @(negedge clk);
      ps2_clock = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clock = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // kind: 0 good, 1 parity inverted, 2 stop bit low
  task automatic send_frame(input logic [7:0] b, input int kind, input bit glitch);
    if (kind == 0) begin
      if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(b);
    end else begin
      exp_err = 1'b1;
    end
    drive_bits(frame_bits(b, kind == 1, kind == 2), 11, glitch);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    exp_err = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_error"}, {31'd0, frame_error}, {31'd0, exp_err});
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  // Waits (bounded) for every predicted byte to be read out.
  task automatic drain(input string tag);
    int k;
    reading = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || rd_valid) && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_pending_bytes"}, exp_q.size(), 0);
    check({tag, "_rd_valid_empty"}, {31'd0, rd_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
    check({tag, "_frame_error"}, {31'd0, frame_error}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         kind;

    reset     = 1'b1;
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    clear_err = 1'b0;
    reading   = 1'b0;
    exp_err   = 1'b0;
    exp_ovf   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single good byte
    send_frame(8'h41, 0, 1'b0);
    drain("single");
    check_flags("single");

    // Fill the FIFO with no reads, one extra byte overflows
    reading = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(8'h41 + i), 0, 1'b0);
    end
    check_flags("full");
    check("full_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("full_head", {24'd0, rd_data}, 32'h41);
    drain("full");
    pulse_clear();
    check_flags("full_cleared");

    // Parity error
    send_frame(8'h5A, 1, 1'b0);
    drain("parity");
    check_flags("parity");
    pulse_clear();
    check_flags("parity_cleared");

    // Timeout on a partial frame, then a good frame
    drive_bits(frame_bits(8'h1C, 1'b0, 1'b0), 5, 1'b0);
    repeat (TO + 200) @(negedge clk);
    exp_err = 1'b1;
    check_flags("timeout");
    send_frame(8'h1C, 0, 1'b0);
    drain("after_timeout");
    check_flags("after_timeout");
    pulse_clear();

    // Short low glitches on the clock pin during a frame
    send_frame(8'h33, 0, 1'b1);
    drain("glitch");
    check_flags("glitch");

    // Reset mid-frame with an error pending and a byte buffered
    reading = 1'b0;
    send_frame(8'h6D, 2, 1'b0);
    send_frame(8'h77, 0, 1'b0);
    check("pre_reset_rd_valid", {31'd0, rd_valid}, 32'd1);
    check_flags("pre_reset");
    drive_bits(frame_bits(8'h42, 1'b0, 1'b0), 5, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h42, 0, 1'b0);
    drain("after_reset");
    check_flags("after_reset");

    // Randomized frames
    for (int i = 0; i < 20; i++) begin
      b    = 8'($urandom);
      kind = $urandom_range(0, 5);
      send_frame(b, (kind < 4) ? 0 : kind - 3, 1'b0);
      drain("rand");
      check_flags("rand");
      if ($urandom_range(0, 1) == 1) begin
        pulse_clear();
        check_flags("rand_cleared");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
